// File: rtl/sst_sequencer.sv
// Save-state sequencer: initiator on the mapper save-state register bus.
// Save copies mapper registers 0..REG_CNT-1 into an external state buffer.
// Restore checks the stored mapper index and then writes every other stored
// byte back into the mapper, each write held across a falling M2 edge.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   m2                  CPU M2 (async, synchronised here)
//   start, mode         command strobe; mode 0 = save, 1 = restore
//   busy, done, err     status (err sticky until next accepted start)
//   sst_act/we_reg/addr/dato, sst_di   mapper save-state bus
//   buf_addr/we/dout, buf_din          state buffer (1-clk read latency)
module sst_sequencer #(
    parameter int unsigned REG_CNT    = 128,
    parameter int unsigned IDX_ADDR   = 127,
    parameter int unsigned M2_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       start,
    input  logic       mode,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       sst_act,
    output logic       sst_we_reg,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [7:0] buf_addr,
    output logic       buf_we,
    output logic [7:0] buf_dout,
    input  logic [7:0] buf_din
);

    localparam int unsigned AW = 8;
    localparam int unsigned TW = $clog2(M2_TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_A   = AW'(REG_CNT - 1);
    localparam logic [AW-1:0] IDX_A    = AW'(IDX_ADDR);
    localparam logic [TW-1:0] TMO_LAST = TW'(M2_TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_IDX  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_SV_ADDR = 4'd1;
    localparam logic [3:0] ST_SV_CAP  = 4'd2;
    localparam logic [3:0] ST_RS_IDX  = 4'd3;
    localparam logic [3:0] ST_RS_CHK  = 4'd4;
    localparam logic [3:0] ST_RS_RD   = 4'd5;
    localparam logic [3:0] ST_RS_LAT  = 4'd6;
    localparam logic [3:0] ST_RS_WR   = 4'd7;
    localparam logic [3:0] ST_RS_HOLD = 4'd8;
    localparam logic [3:0] ST_FIN     = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          m2_q1, m2_q2;
    logic          m2_fall_c;

    logic          busy_d, done_d, act_d, we_d, buf_we_d;
    logic [1:0]    err_d;
    logic [AW-1:0] sst_addr_d, sst_dato_d, buf_addr_d, buf_dout_d;

    // M2 synchroniser and falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_q1 <= 1'b0;
            m2_q2 <= 1'b0;
        end else begin
            m2_q1 <= m2;
            m2_q2 <= m2_q1;
        end
    end

    assign m2_fall_c = m2_q2 & ~m2_q1;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            tmo_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_NONE;
            sst_act    <= 1'b0;
            sst_we_reg <= 1'b0;
            sst_addr   <= '0;
            sst_dato   <= '0;
            buf_addr   <= '0;
            buf_we     <= 1'b0;
            buf_dout   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            tmo_q      <= tmo_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            sst_act    <= act_d;
            sst_we_reg <= we_d;
            sst_addr   <= sst_addr_d;
            sst_dato   <= sst_dato_d;
            buf_addr   <= buf_addr_d;
            buf_we     <= buf_we_d;
            buf_dout   <= buf_dout_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        tmo_d      = tmo_q;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        act_d      = sst_act;
        we_d       = sst_we_reg;
        sst_addr_d = sst_addr;
        sst_dato_d = sst_dato;
        buf_addr_d = buf_addr;
        buf_we_d   = 1'b0;
        buf_dout_d = buf_dout;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d  = ERR_NONE;
                    a_d    = '0;
                    busy_d = 1'b1;
                    act_d  = 1'b1;
                    if (mode) begin
                        state_d    = ST_RS_IDX;
                        sst_addr_d = IDX_A;
                        buf_addr_d = IDX_A;
                    end else begin
                        state_d    = ST_SV_ADDR;
                        sst_addr_d = '0;
                    end
                end
            end

            // sst_addr has settled for a full clk; capture the readback
            ST_SV_ADDR: begin
                state_d    = ST_SV_CAP;
                buf_addr_d = a_q;
                buf_dout_d = sst_di;
                buf_we_d   = 1'b1;
            end

            ST_SV_CAP: begin
                if (a_q == LAST_A) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    act_d   = 1'b0;
                end else begin
                    a_d        = a_q + AW'(1);
                    sst_addr_d = a_q + AW'(1);
                    state_d    = ST_SV_ADDR;
                end
            end

            ST_RS_IDX: state_d = ST_RS_CHK;

            // buf_din now holds the stored index; sst_di the live one
            ST_RS_CHK: begin
                if (buf_din != sst_di) begin
                    err_d   = ERR_IDX;
                    busy_d  = 1'b0;
                    act_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    a_d        = '0;
                    buf_addr_d = '0;
                    state_d    = ST_RS_RD;
                end
            end

            // buf_addr == a during this state; the index register is skipped
            ST_RS_RD: begin
                if (a_q == IDX_A) begin
                    if (a_q == LAST_A) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        act_d   = 1'b0;
                    end else begin
                        a_d        = a_q + AW'(1);
                        buf_addr_d = a_q + AW'(1);
                    end
                end else begin
                    state_d = ST_RS_LAT;
                end
            end

            ST_RS_LAT: begin
                sst_dato_d = buf_din;
                sst_addr_d = a_q;
                we_d       = 1'b1;
                tmo_d      = '0;
                state_d    = ST_RS_WR;
            end

            ST_RS_WR: begin
                if (m2_fall_c) begin
                    state_d = ST_RS_HOLD;
                end else if (tmo_q == TMO_LAST) begin
                    we_d    = 1'b0;
                    err_d   = ERR_TMO;
                    busy_d  = 1'b0;
                    act_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            // One extra clk of write strobe covers synchroniser skew
            ST_RS_HOLD: begin
                we_d = 1'b0;
                if (a_q == LAST_A) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    act_d   = 1'b0;
                end else begin
                    a_d        = a_q + AW'(1);
                    buf_addr_d = a_q + AW'(1);
                    state_d    = ST_RS_RD;
                end
            end

            ST_FIN: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sst_sequencer.sv
`timescale 1ns/1ps
module tb_sst_sequencer;

    localparam int unsigned REG_CNT    = 128;
    localparam int unsigned IDX_ADDR   = 127;
    localparam int unsigned M2_TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m2 = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       busy, done, sst_act, sst_we_reg, buf_we;
    logic [1:0] err;
    logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_dout;
    logic [7:0] buf_din = 8'h00;

    // Mapper register model and state buffer model
    logic [7:0] mreg [256];
    logic [7:0] bufm [256];
    int         wcnt [256];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  done_cnt = 0;
    int  we_pulses = 0;
    int  we_cycles = 0;
    bit  m2_auto = 1'b1;
    bit  op_save = 1'b0;
    logic       we_prev = 1'b0;
    logic [7:0] prev_addr, prev_dato, prev_baddr;
    logic [7:0] we_last_addr = 8'h00;

    sst_sequencer #(
        .REG_CNT(REG_CNT), .IDX_ADDR(IDX_ADDR), .M2_TIMEOUT(M2_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .start(start), .mode(mode),
        .busy(busy), .done(done), .err(err), .sst_act(sst_act),
        .sst_we_reg(sst_we_reg), .sst_addr(sst_addr), .sst_dato(sst_dato),
        .sst_di(sst_di), .buf_addr(buf_addr), .buf_we(buf_we),
        .buf_dout(buf_dout), .buf_din(buf_din)
    );

    always #5 clk = ~clk;

    assign sst_di = mreg[sst_addr];

    // Mapper latches the bus on falling M2 while the write strobe is up
    always @(negedge m2) begin
        if (sst_we_reg) begin
            mreg[sst_addr] = sst_dato;
            wcnt[sst_addr] = wcnt[sst_addr] + 1;
        end
    end

    // Synchronous state buffer, read data one clk after address
    always @(posedge clk) begin
        buf_din <= bufm[buf_addr];
        if (buf_we) bufm[buf_addr] = buf_dout;
    end

    // Responsive CPU: drops M2 a couple of clocks into each register write
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m2_auto && sst_we_reg && m2) begin
                repeat (2) @(posedge clk);
                #3 m2 = 1'b0;
                repeat (4) @(posedge clk);
                #3 m2 = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs_zero(input string name);
        chk(name, {busy, done, err, sst_act, sst_we_reg, sst_addr, sst_dato,
                   buf_addr, buf_we, buf_dout}, 64'd0);
    endtask

    // Per-cycle checks of bus rules against the array models
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (sst_we_reg && !we_prev) begin
                we_pulses++;
                we_last_addr = sst_addr;
            end
            if (sst_we_reg) we_cycles++;
            chk("act_eq_busy", {63'd0, sst_act}, {63'd0, busy});
            if (buf_we) chk("save_capture", {56'd0, buf_dout}, {56'd0, mreg[buf_addr]});
            if (op_save) chk("no_we_in_save", {63'd0, sst_we_reg}, 64'd0);
            if (sst_we_reg) begin
                chk("wr_data", {56'd0, sst_dato}, {56'd0, bufm[sst_addr]});
                chk("wr_not_idx", {63'd0, sst_addr == 8'(IDX_ADDR)}, 64'd0);
                if (we_prev)
                    chk("wr_stable", {40'd0, sst_addr, sst_dato, buf_addr},
                        {40'd0, prev_addr, prev_dato, prev_baddr});
            end
            we_prev    = sst_we_reg;
            prev_addr  = sst_addr;
            prev_dato  = sst_dato;
            prev_baddr = buf_addr;
        end else begin
            we_prev = 1'b0;
        end
    end

    // Issue one command and wait for busy to drop; optional stray starts
    task automatic run_op(input logic md, input int inj_at, input int budget,
                          output int busy_cyc, output logic done_end);
        bit ended;
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        ended = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            busy_cyc++;
            if (inj_at >= 0) begin
                if (i == inj_at)           begin start = 1'b1; mode = ~md; end
                else if (i == inj_at + 1)  begin start = 1'b0; mode = md;  end
                else if (i == inj_at + 60) begin start = 1'b1; mode = md;  end
                else if (i == inj_at + 61) begin start = 1'b0;             end
            end
            @(negedge clk);
        end
        done_end = done;
        chk("op_terminates", {63'd0, ended}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc, d0, w0, wc0, bad;
        logic de;
        bit   found;

        for (int k = 0; k < 256; k++) begin
            mreg[k] = 8'h00;
            bufm[k] = 8'h00;
            wcnt[k] = 0;
        end
        for (int k = 0; k < 127; k++) mreg[k] = 8'(k) ^ 8'h5A;
        mreg[127] = 8'h52;

        // Reset values
        #12;
        chk_outs_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs_zero("idle_after_reset");

        // Save
        d0 = done_cnt; w0 = we_pulses;
        op_save = 1'b1;
        run_op(1'b0, -1, 400, bc, de);
        op_save = 1'b0;
        chk("save_busy_cycles", 64'(bc), 64'd256);
        chk("save_done_at_end", {63'd0, de}, 64'd1);
        @(negedge clk);
        chk("save_done_once", 64'(done_cnt - d0), 64'd1);
        chk("save_no_we", 64'(we_pulses - w0), 64'd0);
        chk("save_err", {62'd0, err}, 64'd0);
        bad = 0;
        for (int k = 0; k < 127; k++) if (bufm[k] !== (8'(k) ^ 8'h5A)) bad++;
        chk("save_buf_entries_bad", 64'(bad), 64'd0);
        chk("save_buf0", {56'd0, bufm[0]}, 64'h5A);
        chk("save_buf1", {56'd0, bufm[1]}, 64'h5B);
        chk("save_buf126", {56'd0, bufm[126]}, 64'h24);
        chk("save_buf127", {56'd0, bufm[127]}, 64'h52);

        // Restore with matching index
        for (int k = 0; k < 127; k++) bufm[k] = ~8'(k);
        bufm[127] = 8'h52;
        d0 = done_cnt;
        run_op(1'b1, -1, 5000, bc, de);
        chk("rs_done_at_end", {63'd0, de}, 64'd1);
        @(negedge clk);
        chk("rs_done_once", 64'(done_cnt - d0), 64'd1);
        chk("rs_err", {62'd0, err}, 64'd0);
        for (int k = 0; k < 127; k++) begin
            chk("rs_reg_value", {56'd0, mreg[k]}, {56'd0, ~8'(k)});
            chk("rs_reg_writes", 64'(wcnt[k]), 64'd1);
        end
        chk("rs_idx_writes", 64'(wcnt[127]), 64'd0);
        chk("rs_reg0", {56'd0, mreg[0]}, 64'hFF);
        chk("rs_reg126", {56'd0, mreg[126]}, 64'h81);
        chk("rs_reg127", {56'd0, mreg[127]}, 64'h52);

        // Restore with wrong index
        bufm[127] = 8'h41;
        d0 = done_cnt; w0 = we_pulses;
        run_op(1'b1, -1, 50, bc, de);
        chk("idx_busy_within_3", {63'd0, bc <= 3}, 64'd1);
        chk("idx_err", {62'd0, err}, 64'd1);
        chk("idx_no_we", 64'(we_pulses - w0), 64'd0);
        @(negedge clk);
        chk("idx_no_done", 64'(done_cnt - d0), 64'd0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (wcnt[k] != ((k < 127) ? 1 : 0)) bad++;
        chk("idx_no_mapper_writes", 64'(bad), 64'd0);

        // Restore with M2 stuck high
        bufm[127] = 8'h52;
        m2_auto = 1'b0;
        d0 = done_cnt; w0 = we_pulses; wc0 = we_cycles;
        run_op(1'b1, -1, 3000, bc, de);
        chk("tmo_err", {62'd0, err}, 64'd2);
        chk("tmo_we_low", {63'd0, sst_we_reg}, 64'd0);
        chk("tmo_we_cycles", 64'(we_cycles - wc0), 64'(M2_TIMEOUT));
        chk("tmo_one_attempt", 64'(we_pulses - w0), 64'd1);
        chk("tmo_attempt_addr", {56'd0, we_last_addr}, 64'd0);
        @(negedge clk);
        chk("tmo_no_done", 64'(done_cnt - d0), 64'd0);
        chk("tmo_reg0_untouched", 64'(wcnt[0]), 64'd1);
        m2_auto = 1'b1;

        // Reset in the middle of a restore write to register 40
        for (int k = 0; k < 127; k++) bufm[k] = 8'(k) ^ 8'hC3;
        @(negedge clk);
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (sst_we_reg && sst_addr == 8'd40) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reached_a40", {63'd0, found}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_async_outputs");
        chk("rst_we_low", {63'd0, sst_we_reg}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_reg40_kept", {56'd0, mreg[40]}, 64'hD7);
        chk("rst_reg40_writes", 64'(wcnt[40]), 64'd1);
        chk("rst_reg39_written", {56'd0, mreg[39]}, 64'hE4);
        chk("rst_idle", {63'd0, busy}, 64'd0);

        // Save with stray start pulses and a mode flip mid-operation
        for (int k = 0; k < 256; k++) bufm[k] = 8'h00;
        d0 = done_cnt; w0 = we_pulses;
        op_save = 1'b1;
        run_op(1'b0, 50, 400, bc, de);
        op_save = 1'b0;
        chk("stray_busy_cycles", 64'(bc), 64'd256);
        @(negedge clk);
        chk("stray_done_once", 64'(done_cnt - d0), 64'd1);
        chk("stray_no_we", 64'(we_pulses - w0), 64'd0);
        bad = 0;
        for (int k = 0; k < 128; k++) if (bufm[k] !== mreg[k]) bad++;
        chk("stray_buf_bad", 64'(bad), 64'd0);
        chk("stray_buf39", {56'd0, bufm[39]}, 64'hE4);
        chk("stray_buf40", {56'd0, bufm[40]}, 64'hD7);
        chk("stray_buf127", {56'd0, bufm[127]}, 64'h52);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
